aether_config_writer: RTL and testbench

Register-bus initiator that programs one Aether engine run. On a start pulse it snapshots the run configuration and reads the Version register (0x1) to check chip identity. It then packs the configuration into the Base Config 1–3 (0x5–0x7) and Conv Run Param 1 (0x8) register words and writes them in order. It sits between the host-side layer sequencer and the engine's register file, and produces exactly the field layout the engine's register decoders consume.

---
 rtl/aether_config_writer.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_aether_config_writer.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aether_config_writer.sv
// -----------------------------------------------------------------------------
// aether_config_writer
//
// Register-bus initiator that programs one Aether engine run. A start request
// snapshots the run configuration, reads the Version register (0x1) to check
// chip identity and major revision, then writes the packed Base Config 1..3
// (0x5..0x7) and Conv Run Param 1 (0x8) words in that order.
//
// Parameters
//   EXPECTED_CHIP_ID  required Version[15:8]
//   MIN_MAJOR         minimum accepted Version[7:3]
//   TIMEOUT_CYCLES    cycles to wait for the read response (>= 1)
//
// Ports
//   clk_i, rst_ni         clock (rising edge), asynchronous active-low reset
//   start_i               begin a sequence (sampled only while idle)
//   shift_i .. save_to_buffer_i
//                         run configuration, latched on an accepted start
//   reg_valid_o/ready_i   request handshake (accepted when both high)
//   reg_write_o           1 = write, 0 = read
//   reg_addr_o            register address
//   reg_wdata_o           write data (0 on reads)
//   reg_rvalid_i/rdata_i  read response
//   busy_o                sequence in progress (low during the done cycle)
//   done_o                one-cycle completion pulse, success or error
//   error_o               sticky error, cleared by the next accepted start
//   version_o             last captured Version word
// -----------------------------------------------------------------------------
module aether_config_writer #(
  parameter logic [7:0]  EXPECTED_CHIP_ID = 8'hAE,
  parameter logic [4:0]  MIN_MAJOR        = 5'd1,
  parameter int unsigned TIMEOUT_CYCLES   = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [5:0]  shift_i,
  input  logic [11:0] engine_count_i,
  input  logic [13:0] matrix_size_i,
  input  logic [1:0]  load_from_i,
  input  logic [2:0]  padding_i,
  input  logic        padding_fill_i,
  input  logic [5:0]  stride_i,
  input  logic [2:0]  activation_i,
  input  logic        accumulate_i,
  input  logic        save_to_ram_i,
  input  logic        save_to_buffer_i,
  output logic        reg_valid_o,
  input  logic        reg_ready_i,
  output logic        reg_write_o,
  output logic [3:0]  reg_addr_o,
  output logic [15:0] reg_wdata_o,
  input  logic        reg_rvalid_i,
  input  logic [15:0] reg_rdata_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] version_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] ADDR_VERSION = 4'h1;
  localparam logic [3:0] ADDR_BASE1   = 4'h5;
  localparam logic [3:0] ADDR_BASE2   = 4'h6;
  localparam logic [3:0] ADDR_BASE3   = 4'h7;
  localparam logic [3:0] ADDR_CONV1   = 4'h8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_VER,
    S_WAIT_VER,
    S_WR5,
    S_WR6,
    S_WR7,
    S_WR8,
    S_DONE
  } state_e;

  // Shadow copy of the run configuration, frozen for the whole sequence.
  typedef struct packed {
    logic [5:0]  shift;
    logic [11:0] engine_count;
    logic [13:0] matrix_size;
    logic [1:0]  load_from;
    logic [2:0]  padding;
    logic        padding_fill;
    logic [5:0]  stride;
    logic [2:0]  activation;
    logic        accumulate;
    logic        save_to_ram;
    logic        save_to_buffer;
  } cfg_t;

  // ---------------------------------------------------------------------------
  // Register word packing: the exact field layout the engine decoders expect.
  // ---------------------------------------------------------------------------
  function automatic logic [15:0] pack_base1(input cfg_t c);
    return {c.shift[3:0], c.engine_count};
  endfunction

  function automatic logic [15:0] pack_base2(input cfg_t c);
    return {c.shift[5:4], c.matrix_size};
  endfunction

  function automatic logic [15:0] pack_base3(input cfg_t c);
    return {c.load_from, 14'd0};
  endfunction

  function automatic logic [15:0] pack_conv1(input cfg_t c);
    return {c.padding, c.padding_fill, c.stride, c.activation,
            c.accumulate, c.save_to_ram, c.save_to_buffer};
  endfunction

  function automatic logic version_ok(input logic [15:0] v);
    return (v[15:8] == EXPECTED_CHIP_ID) && (v[7:3] >= MIN_MAJOR);
  endfunction

  state_e           state_q, state_d;
  cfg_t             cfg_q, cfg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             error_q, error_d;
  logic [15:0]      version_q, version_d;
  logic             valid_q, valid_d;
  logic             write_q, write_d;
  logic [3:0]       addr_q, addr_d;
  logic [15:0]      wdata_q, wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             req_hs;

  assign req_hs = valid_q & reg_ready_i;

  // ---------------------------------------------------------------------------
  // State register and registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cfg_q     <= '0;
      cnt_q     <= '0;
      error_q   <= 1'b0;
      version_q <= 16'd0;
      valid_q   <= 1'b0;
      write_q   <= 1'b0;
      addr_q    <= 4'd0;
      wdata_q   <= 16'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cfg_q     <= cfg_d;
      cnt_q     <= cnt_d;
      error_q   <= error_d;
      version_q <= version_d;
      valid_q   <= valid_d;
      write_q   <= write_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Request outputs are derived from the next state so they
  // appear registered in the same cycle the state is entered; while a request
  // is pending the state holds, so addr/wdata/write cannot change before the
  // handshake.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cfg_d     = cfg_q;
    cnt_d     = cnt_q;
    error_d   = error_q;
    version_d = version_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (stride_i != 6'd0) begin
            cfg_d.shift          = shift_i;
            cfg_d.engine_count   = engine_count_i;
            cfg_d.matrix_size    = matrix_size_i;
            cfg_d.load_from      = load_from_i;
            cfg_d.padding        = padding_i;
            cfg_d.padding_fill   = padding_fill_i;
            cfg_d.stride         = stride_i;
            cfg_d.activation     = activation_i;
            cfg_d.accumulate     = accumulate_i;
            cfg_d.save_to_ram    = save_to_ram_i;
            cfg_d.save_to_buffer = save_to_buffer_i;
            error_d              = 1'b0;
            state_d              = S_RD_VER;
          end else begin
            // Zero stride would hang the engine: reject without bus traffic.
            error_d = 1'b1;
            state_d = S_DONE;
          end
        end
      end

      S_RD_VER: begin
        if (req_hs) begin
          cnt_d   = CNT_W'(TIMEOUT_CYCLES);
          state_d = S_WAIT_VER;
        end
      end

      S_WAIT_VER: begin
        // A response in the same cycle the counter hits zero still counts.
        if (reg_rvalid_i) begin
          version_d = reg_rdata_i;
          if (version_ok(reg_rdata_i)) begin
            state_d = S_WR5;
          end else begin
            error_d = 1'b1;
            state_d = S_DONE;
          end
        end else if (cnt_q == '0) begin
          error_d = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_WR5: if (req_hs) state_d = S_WR6;
      S_WR6: if (req_hs) state_d = S_WR7;
      S_WR7: if (req_hs) state_d = S_WR8;
      S_WR8: if (req_hs) state_d = S_DONE;

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    valid_d = 1'b0;
    write_d = 1'b0;
    addr_d  = 4'd0;
    wdata_d = 16'd0;
    case (state_d)
      S_RD_VER: begin
        valid_d = 1'b1;
        addr_d  = ADDR_VERSION;
      end
      S_WR5: begin
        valid_d = 1'b1;
        write_d = 1'b1;
        addr_d  = ADDR_BASE1;
        wdata_d = pack_base1(cfg_d);
      end
      S_WR6: begin
        valid_d = 1'b1;
        write_d = 1'b1;
        addr_d  = ADDR_BASE2;
        wdata_d = pack_base2(cfg_d);
      end
      S_WR7: begin
        valid_d = 1'b1;
        write_d = 1'b1;
        addr_d  = ADDR_BASE3;
        wdata_d = pack_base3(cfg_d);
      end
      S_WR8: begin
        valid_d = 1'b1;
        write_d = 1'b1;
        addr_d  = ADDR_CONV1;
        wdata_d = pack_conv1(cfg_d);
      end
      default: begin
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  assign reg_valid_o = valid_q;
  assign reg_write_o = write_q;
  assign reg_addr_o  = addr_q;
  assign reg_wdata_o = wdata_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign version_o   = version_q;

endmodule

// File: tb/tb_aether_config_writer.sv
module tb_aether_config_writer;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        start_i;
  logic [5:0]  shift_i;
  logic [11:0] engine_count_i;
  logic [13:0] matrix_size_i;
  logic [1:0]  load_from_i;
  logic [2:0]  padding_i;
  logic        padding_fill_i;
  logic [5:0]  stride_i;
  logic [2:0]  activation_i;
  logic        accumulate_i;
  logic        save_to_ram_i;
  logic        save_to_buffer_i;
  logic        reg_valid_o;
  logic        reg_ready_i;
  logic        reg_write_o;
  logic [3:0]  reg_addr_o;
  logic [15:0] reg_wdata_o;
  logic        reg_rvalid_i;
  logic [15:0] reg_rdata_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [15:0] version_o;

  always #5 clk = ~clk;

  aether_config_writer #(
    .EXPECTED_CHIP_ID(8'hAE),
    .MIN_MAJOR       (5'd1),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk_i           (clk),
    .rst_ni          (rst_ni),
    .start_i         (start_i),
    .shift_i         (shift_i),
    .engine_count_i  (engine_count_i),
    .matrix_size_i   (matrix_size_i),
    .load_from_i     (load_from_i),
    .padding_i       (padding_i),
    .padding_fill_i  (padding_fill_i),
    .stride_i        (stride_i),
    .activation_i    (activation_i),
    .accumulate_i    (accumulate_i),
    .save_to_ram_i   (save_to_ram_i),
    .save_to_buffer_i(save_to_buffer_i),
    .reg_valid_o     (reg_valid_o),
    .reg_ready_i     (reg_ready_i),
    .reg_write_o     (reg_write_o),
    .reg_addr_o      (reg_addr_o),
    .reg_wdata_o     (reg_wdata_o),
    .reg_rvalid_i    (reg_rvalid_i),
    .reg_rdata_i     (reg_rdata_i),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .version_o       (version_o)
  );

  int checks   = 0;
  int failures = 0;

  // Configuration used for the next run (held by the bench, not the DUT).
  logic [5:0]  s_shift;
  logic [11:0] s_ec;
  logic [13:0] s_ms;
  logic [1:0]  s_lf;
  logic [2:0]  s_pad;
  logic        s_fill;
  logic [5:0]  s_stride;
  logic [2:0]  s_act;
  logic        s_acc, s_ram, s_buf;
  logic [15:0] exp_version;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_cfg();
    shift_i = s_shift; engine_count_i = s_ec; matrix_size_i = s_ms;
    load_from_i = s_lf; padding_i = s_pad; padding_fill_i = s_fill;
    stride_i = s_stride; activation_i = s_act; accumulate_i = s_acc;
    save_to_ram_i = s_ram; save_to_buffer_i = s_buf;
  endtask

  task automatic scramble_cfg();
    shift_i = 6'($urandom); engine_count_i = 12'($urandom); matrix_size_i = 14'($urandom);
    load_from_i = 2'($urandom); padding_i = 3'($urandom); padding_fill_i = 1'($urandom);
    stride_i = 6'($urandom); activation_i = 3'($urandom); accumulate_i = 1'($urandom);
    save_to_ram_i = 1'($urandom); save_to_buffer_i = 1'($urandom);
  endtask

  task automatic random_cfg(input bit allow_zero_stride);
    s_shift = 6'($urandom); s_ec = 12'($urandom); s_ms = 14'($urandom);
    s_lf = 2'($urandom); s_pad = 3'($urandom); s_fill = 1'($urandom);
    s_act = 3'($urandom); s_acc = 1'($urandom); s_ram = 1'($urandom); s_buf = 1'($urandom);
    if (allow_zero_stride && $urandom_range(0, 5) == 0) s_stride = 6'd0;
    else s_stride = 6'($urandom_range(1, 63));
  endtask

  task automatic chk_reset_outputs(input string nm);
    chk({nm, ":valid"},   reg_valid_o, 0);
    chk({nm, ":write"},   reg_write_o, 0);
    chk({nm, ":addr"},    reg_addr_o,  0);
    chk({nm, ":wdata"},   reg_wdata_o, 0);
    chk({nm, ":busy"},    busy_o,      0);
    chk({nm, ":done"},    done_o,      0);
    chk({nm, ":error"},   error_o,     0);
    chk({nm, ":version"}, version_o,   0);
  endtask

  // One complete sequence: start pulse, bus responder, then end-of-run checks
  // against the expected words/outcome computed from the configuration.
  //   lat        : rvalid latency after the read handshake (0 = never)
  //   rnd        : random ready and stray rvalid injection
  //   b2b        : assert start in the done cycle and check it is ignored
  //   abort_addr : stop (leaving ready low) once a write to this addr is pending
  //   fixed_done : if nonzero, absolute done cycle required
  task automatic run(input string nm, input logic [15:0] rdata, input int lat,
                     input bit rnd, input bit b2b, input int abort_addr,
                     input int fixed_done);
    int hs, resp, done_cyc, last_wr, nvld, nrd, exp_done, nwr_exp, rv;
    int sh, w[4];
    bit pend, exp_err, delivered, pass;
    logic [3:0]  pa;
    logic [15:0] pd;
    logic        pw;
    logic [3:0]  qa[$];
    logic [15:0] qd[$];

    sh   = int'(s_shift);
    w[0] = (sh % 16) * 4096 + int'(s_ec);
    w[1] = (sh / 16) * 16384 + int'(s_ms);
    w[2] = int'(s_lf) * 16384;
    w[3] = int'(s_pad) * 8192 + int'(s_fill) * 4096 + int'(s_stride) * 64 +
           int'(s_act) * 8 + int'(s_acc) * 4 + int'(s_ram) * 2 + int'(s_buf);

    drive_cfg();
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;

    hs = -1; resp = -1; done_cyc = -1; last_wr = -1; nvld = 0; nrd = 0;
    pend = 1'b0; pa = '0; pd = '0; pw = 1'b0;
    for (int cyc = 1; cyc <= 200 && done_cyc < 0; cyc++) begin
      scramble_cfg();
      if (cyc == 1) begin
        chk({nm, ":valid_rise"}, reg_valid_o, (s_stride != 0));
        chk({nm, ":error_at_start"}, error_o, (s_stride == 0));
      end
      if (pend) begin
        chk({nm, ":held_valid"}, reg_valid_o, 1);
        chk({nm, ":held_addr"},  reg_addr_o,  pa);
        chk({nm, ":held_wdata"}, reg_wdata_o, pd);
        chk({nm, ":held_write"}, reg_write_o, pw);
      end
      if (reg_valid_o) nvld++;
      if (done_o) begin
        done_cyc = cyc;
        chk({nm, ":busy_in_done"},  busy_o,      0);
        chk({nm, ":valid_in_done"}, reg_valid_o, 0);
        reg_ready_i  = 1'b0;
        reg_rvalid_i = 1'b0;
        if (b2b) start_i = 1'b1;
      end else begin
        chk({nm, ":busy"}, busy_o, 1);
        reg_ready_i = rnd ? ($urandom_range(0, 99) < 60) : 1'b1;
        if (abort_addr != 0 && reg_valid_o && reg_write_o && int'(reg_addr_o) == abort_addr) begin
          reg_ready_i  = 1'b0;
          reg_rvalid_i = 1'b0;
          return;
        end
        if (hs >= 0 && lat != 0 && cyc == hs + lat) begin
          reg_rvalid_i = 1'b1;
          reg_rdata_i  = rdata;
          resp         = cyc;
        end else if (rnd && (hs < 0 || resp >= 0) && $urandom_range(0, 3) == 0) begin
          reg_rvalid_i = 1'b1;
          reg_rdata_i  = 16'($urandom);
        end else begin
          reg_rvalid_i = 1'b0;
          reg_rdata_i  = 16'($urandom);
        end
        if (reg_valid_o && reg_ready_i) begin
          if (!reg_write_o) begin
            nrd++;
            hs = cyc;
            chk({nm, ":rd_addr"},  reg_addr_o,  4'h1);
            chk({nm, ":rd_wdata"}, reg_wdata_o, 0);
          end else begin
            qa.push_back(reg_addr_o);
            qd.push_back(reg_wdata_o);
            last_wr = cyc;
          end
        end
        pend = reg_valid_o && !reg_ready_i;
        pa = reg_addr_o; pd = reg_wdata_o; pw = reg_write_o;
      end
      @(posedge clk); #1;
    end
    reg_rvalid_i = 1'b0;

    chk({nm, ":done_seen"}, (done_cyc > 0), 1);
    if (s_stride == 0) begin
      exp_err  = 1'b1;
      exp_done = 1;
      nwr_exp  = 0;
      chk({nm, ":no_traffic"}, nvld, 0);
    end else begin
      chk({nm, ":reads"}, nrd, 1);
      delivered = (lat != 0) && (lat <= TO + 1);
      if (delivered) begin
        rv          = int'(rdata);
        exp_version = rdata;
        pass        = ((rv / 256) == 'hAE) && (((rv / 8) % 32) >= 1);
        exp_err     = !pass;
        nwr_exp     = pass ? 4 : 0;
        exp_done    = pass ? last_wr + 1 : hs + lat + 1;
      end else begin
        exp_err  = 1'b1;
        nwr_exp  = 0;
        exp_done = hs + TO + 2;
      end
    end
    if (fixed_done != 0) exp_done = fixed_done;
    chk({nm, ":done_cycle"}, done_cyc, exp_done);
    chk({nm, ":error"},      error_o,  exp_err);
    chk({nm, ":version"},    version_o, exp_version);
    chk({nm, ":n_writes"},   qa.size(), nwr_exp);
    if (qa.size() == nwr_exp) begin
      for (int i = 0; i < nwr_exp; i++) begin
        chk({nm, $sformatf(":wr%0d_addr", i)}, qa[i], 5 + i);
        chk({nm, $sformatf(":wr%0d_data", i)}, qd[i], w[i]);
      end
    end
    if (b2b) begin
      chk({nm, ":b2b_ignored_valid"}, reg_valid_o, 0);
      chk({nm, ":b2b_ignored_busy"},  busy_o,      0);
      chk({nm, ":b2b_ignored_done"},  done_o,      0);
    end
  endtask

  task automatic nominal_cfg();
    s_shift = 6'h2B; s_ec = 12'h040; s_ms = 14'h01C; s_lf = 2'b01;
    s_pad = 3'd1; s_fill = 1'b0; s_stride = 6'd1; s_act = 3'd2;
    s_acc = 1'b0; s_ram = 1'b1; s_buf = 1'b0;
  endtask

  initial begin
    logic [15:0] rd;
    rst_ni = 1'b0; start_i = 1'b0; reg_ready_i = 1'b0;
    reg_rvalid_i = 1'b0; reg_rdata_i = 16'd0;
    nominal_cfg(); drive_cfg();
    exp_version = 16'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    #2 rst_ni = 1'b1;
    @(posedge clk); #1;

    // Nominal zero-wait run with the reference configuration.
    nominal_cfg();
    run("nominal", 16'hAE08, 1, 1'b0, 1'b0, 0, 7);

    // Chip-ID mismatch, with a start asserted during the done cycle.
    random_cfg(1'b0);
    run("chip_id", 16'hAD08, 1, 1'b0, 1'b1, 0, 0);

    // Next accepted start clears the sticky error.
    random_cfg(1'b0);
    run("after_err", 16'hAE10, 1, 1'b0, 1'b0, 0, 7);

    // Major revision below the minimum.
    random_cfg(1'b0);
    run("low_major", 16'hAE07, 2, 1'b0, 1'b0, 0, 0);

    // No read response at all.
    random_cfg(1'b0);
    run("timeout", 16'hAE08, 0, 1'b0, 1'b0, 0, 7);

    // Zero stride is rejected without bus traffic.
    random_cfg(1'b0);
    s_stride = 6'd0;
    run("stride0", 16'hAE08, 1, 1'b0, 1'b0, 0, 1);

    // Randomized backpressure and response latency.
    for (int i = 0; i < 12; i++) begin
      random_cfg(1'b1);
      if ($urandom_range(0, 3) == 0) rd = 16'($urandom);
      else rd = {8'hAE, 5'($urandom_range(0, 4)), 3'($urandom)};
      run($sformatf("rand%0d", i), rd, int'($urandom_range(1, 5)), 1'b1, 1'b0, 0, 0);
    end

    // Reset while the write to 0x6 is waiting for ready.
    nominal_cfg();
    run("abort", 16'hAE08, 1, 1'b0, 1'b0, 6, 0);
    #2 rst_ni = 1'b0;
    #1;
    chk_reset_outputs("mid_reset");
    exp_version = 16'd0;
    @(posedge clk); @(posedge clk);
    #3 rst_ni = 1'b1;
    @(posedge clk); #1;
    random_cfg(1'b0);
    run("post_reset", 16'hAE08, 1, 1'b0, 1'b0, 0, 7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
